btn_debouncer: RTL and testbench

//   Debounces one raw mechanical push-button input and emits a single-clock

---
 rtl/btn_debouncer.sv | 106 ++++++++++
 tb/tb_btn_debouncer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_debouncer.sv
// -----------------------------------------------------------------------------
// btn_debouncer
//   Debounces one raw mechanical push-button and emits a single-clock
//   increment pulse for every debounced press (0->1 of the debounced level).
//   The raw level is first synchronised with two flops. It is then sampled
//   once every DIV clocks into an N-bit history. The debounced level changes
//   only when all N samples in the history agree, so contact chatter is
//   rejected.
//
// Parameters
//   DIV  clocks per sample tick (>= 2)
//   N    consecutive agreeing samples needed to change the level (>= 2)
//
// Ports
//   clk        in   system clock, all state updates on the rising edge
//   rst        in   asynchronous, active-low reset
//   btn_raw    in   raw asynchronous button level, 1 = pressed
//   inc_pulse  out  registered pulse, high for one clk per debounced press
// -----------------------------------------------------------------------------
module btn_debouncer #(
    parameter int DIV = 8,
    parameter int N   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic inc_pulse
);

    localparam int             CW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(DIV - 1);

    logic          sync_q1;
    logic          btn_s;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [N-1:0]  hist;
    logic [N-1:0]  hist_next;
    logic          all_ones;
    logic          all_zeros;
    logic          debounced;
    logic          debounced_q;

    // The level decision looks at the history as it will be after this
    // tick's shift. Doing so lets the Nth agreeing sample take effect on the
    // same edge, instead of one tick later.
    always_comb begin
        tick      = (tick_cnt == TICK_LAST);
        hist_next = {hist[N-2:0], btn_s};
        all_ones  = &hist_next;
        all_zeros = ~|hist_next;
    end

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            btn_s   <= sync_q1;
        end
    end

    // Free-running sample divider. The tick is high during the cycle in which
    // the counter holds DIV-1, so the first sample lands DIV clocks after
    // reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    // Sample history (newest sample in bit 0) and the debounced level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist      <= '0;
            debounced <= 1'b0;
        end else if (tick) begin
            hist <= hist_next;
            if (all_ones && !debounced) begin
                debounced <= 1'b1;
            end else if (all_zeros && debounced) begin
                debounced <= 1'b0;
            end
        end
    end

    // The pulse is the registered rising edge of the debounced level. It
    // appears one clock after the level rises and lasts exactly one clock.
    // A release (1->0) produces no pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            debounced_q <= 1'b0;
            inc_pulse   <= 1'b0;
        end else begin
            debounced_q <= debounced;
            inc_pulse   <= debounced & ~debounced_q;
        end
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer with DIV=8 and N=3.
// A cycle-indexed reference model predicts inc_pulse on every clock. The
// model uses the edge number since reset to find the ticks, a log of the
// raw input to find the synchronised value, and a queue of the last N
// samples to decide the level. Directed phases then pin the pulse counts
// and latencies with hand-computed literals.
module tb_btn_debouncer;

  localparam int DIV = 8;
  localparam int N   = 3;

  logic clk;
  logic rst;
  logic btn_raw;
  logic inc_pulse;

  int checks;
  int failures;
  int cyc;
  int pulse_count;
  int last_pulse_cyc;
  logic prev_inc;

  btn_debouncer #(.DIV(DIV), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .inc_pulse (inc_pulse)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // k counts rising edges since reset was released; edge 1 is the first.
  // The value the synchronised input shows before edge k was the raw level
  // seen at edge k-2. A sample is taken at every edge that is a multiple of
  // DIV.
  int   k;
  int   raw_log[$];
  bit   samp_q[$];
  bit   lvl;
  int   rise_edge;
  bit   exp_inc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k = 0;
      raw_log.delete();
      samp_q.delete();
      for (int i = 0; i < N; i++) samp_q.push_back(1'b0);
      lvl       = 1'b0;
      rise_edge = -10;
      exp_inc   = 1'b0;
    end else begin
      int ones;
      bit s;
      k = k + 1;
      raw_log.push_back(int'(btn_raw));
      if (k % DIV == 0) begin
        s = (k >= 3) ? bit'(raw_log[k-3]) : 1'b0;
        samp_q.push_back(s);
        void'(samp_q.pop_front());
        ones = 0;
        foreach (samp_q[i]) ones += int'(samp_q[i]);
        if (ones == N && !lvl) begin
          lvl       = 1'b1;
          rise_edge = k;
        end else if (ones == 0 && lvl) begin
          lvl = 1'b0;
        end
      end
      exp_inc = (rise_edge == k - 1);
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    checks = checks + 1;
    if (inc_pulse !== exp_inc) begin
      failures = failures + 1;
      $display("FAIL model_cmp cyc=%0d inc_pulse=%b expected=%b", cyc, inc_pulse, exp_inc);
    end
    if (inc_pulse === 1'b1) begin
      pulse_count    = pulse_count + 1;
      last_pulse_cyc = cyc;
      checks = checks + 1;
      if (prev_inc === 1'b1) begin
        failures = failures + 1;
        $display("FAIL pulse_width cyc=%0d inc_pulse high on two consecutive clks, required single clk", cyc);
      end
    end
    prev_inc = inc_pulse;
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    btn_raw = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle(input int n);
    repeat (n) begin
      btn_raw = ~btn_raw;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int press_cyc;
    int lat;
    int glitch_len;

    checks         = 0;
    failures       = 0;
    cyc            = 0;
    pulse_count    = 0;
    last_pulse_cyc = -1;
    prev_inc       = 1'b0;
    rst            = 1'b0;
    btn_raw        = 1'b0;

    // Reset held for 10 clocks with the button idle.
    repeat (10) @(posedge clk);
    #1;
    check_eq("reset_inc_pulse", int'(inc_pulse), 0);
    check_eq("reset_no_pulse", pulse_count, 0);
    rst = 1'b1;

    // Chatter on press and on release: exactly one pulse overall.
    p0 = pulse_count;
    hold(1'b0, 30);
    toggle(30);
    hold(1'b1, 48);
    toggle(20);
    hold(1'b0, 48);
    check_eq("chatter_pulses", pulse_count - p0, 1);

    // Clean press. The fastest path is tick on sync edge 3 (pulse at 20);
    // the slowest is a tick just missed (pulse at 27).
    p0        = pulse_count;
    press_cyc = cyc;
    hold(1'b1, 28);
    check_eq("clean_press_pulses", pulse_count - p0, 1);
    lat = last_pulse_cyc - press_cyc;
    check_eq("clean_press_latency_in_20_27", int'(lat >= 20 && lat <= 27), 1);
    hold(1'b1, 20);
    check_eq("held_no_repeat", pulse_count - p0, 1);
    check_eq("full_sequence_total", pulse_count, 2);

    // Release after a press does not pulse.
    p0 = pulse_count;
    hold(1'b0, 48);
    check_eq("release_no_pulse", pulse_count - p0, 0);

    // Glitch shorter than one tick period.
    p0         = pulse_count;
    glitch_len = $urandom_range(1, DIV - 1);
    hold(1'b1, glitch_len);
    hold(1'b0, 40);
    check_eq("short_glitch_no_pulse", pulse_count - p0, 0);

    // Press, then reset while the level is high and the button is held.
    p0 = pulse_count;
    hold(1'b1, 40);
    check_eq("pre_reset_press", pulse_count - p0, 1);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_reset_inc_pulse", int'(inc_pulse), 0);
    // Release the reset with the button still held. Ticks fall at edges 8,
    // 16 and 24 (sync is valid from edge 2), so the level rises at 24 and
    // the pulse appears at 25.
    rst       = 1'b1;
    press_cyc = cyc;
    p0        = pulse_count;
    hold(1'b1, 30);
    check_eq("post_reset_pulses", pulse_count - p0, 1);
    check_eq("post_reset_latency", last_pulse_cyc - press_cyc, DIV * N + 1);
    p0 = pulse_count;
    hold(1'b0, 48);
    check_eq("final_release_no_pulse", pulse_count - p0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
